// File: rtl/layer_sched_pkg.sv
// -----------------------------------------------------------------------------
// layer_sched_pkg
// Shared definitions for the layer scheduler:
//   - bit positions of the one-hot phase vector (IDLE..WB)
//   - one-hot phase encoding used by the scheduler FSM
//   - layer descriptor type encodings
//   - default watchdog expiry count
//   - first_phase(): first phase a layer enters, given its descriptor type
// -----------------------------------------------------------------------------
package layer_sched_pkg;

    localparam int PH_IDLE     = 0;
    localparam int PH_WEIGHT   = 1;
    localparam int PH_FEAT     = 2;
    localparam int PH_CONV     = 3;
    localparam int PH_UPSAMPLE = 4;
    localparam int PH_WB       = 5;
    localparam int NUM_PH      = 6;

    typedef enum logic [NUM_PH-1:0] {
        ST_IDLE     = 6'b1 << PH_IDLE,
        ST_WEIGHT   = 6'b1 << PH_WEIGHT,
        ST_FEAT     = 6'b1 << PH_FEAT,
        ST_CONV     = 6'b1 << PH_CONV,
        ST_UPSAMPLE = 6'b1 << PH_UPSAMPLE,
        ST_WB       = 6'b1 << PH_WB
    } phase_t;

    typedef enum logic [1:0] {
        LT_CONV      = 2'd0,
        LT_CONV_POOL = 2'd1,
        LT_UPSAMPLE  = 2'd2,
        LT_RSVD      = 2'd3
    } layer_type_t;

    localparam logic [19:0] WDT_LIMIT_DEFAULT = 20'hF_FFFF;

    // Reserved descriptors map to IDLE; the caller flags the error.
    function automatic phase_t first_phase(input logic [1:0] ltype);
        case (ltype)
            LT_CONV, LT_CONV_POOL: first_phase = ST_WEIGHT;
            LT_UPSAMPLE:           first_phase = ST_UPSAMPLE;
            default:               first_phase = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/layer_sched_wdt.sv
// -----------------------------------------------------------------------------
// layer_sched_wdt
// Per-phase watchdog counter for the layer scheduler.
//   sclk     : system clock (rising edge)
//   s_rst_n  : asynchronous active-low reset, clears the count
//   clr      : clear the count this cycle (phase change or idle)
//   en       : count this cycle (scheduler busy)
//   expired  : the count has reached WDT_LIMIT cycles in the current phase;
//              asserted in the last allowed cycle so the scheduler leaves the
//              phase on that same edge
// -----------------------------------------------------------------------------
module layer_sched_wdt #(
    parameter int               WDT_W     = 20,
    parameter logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(20'hF_FFFF)
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDT_W-1:0] LAST_CNT = WDT_LIMIT - WDT_W'(1);

    logic [WDT_W-1:0] cnt_q;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + WDT_W'(1);
        end
    end

    // A pending phase change always wins over expiry.
    assign expired = en && !clr && (cnt_q == LAST_CNT);

endmodule

// File: rtl/layer_sched.sv
// -----------------------------------------------------------------------------
// layer_sched
// Sequences a network run layer by layer through the datapath phases
// WEIGHT -> FEAT -> CONV -> WB (conv layers) or UPSAMPLE -> WB (upsample
// layers), with a per-phase watchdog and a sticky error flag.
//   sclk, s_rst_n       : clock, asynchronous active-low reset
//   start               : run request pulse (acted on only in IDLE)
//   layer_num           : number of layers minus one, latched on start
//   layer_idx           : current layer, addresses the descriptor ROM
//   layer_type          : descriptor of layer_idx (same-cycle ROM read)
//   weight_done .. wb_done : completion pulses of the datapath stages
//   state               : one-hot phase {WB,UPSAMPLE,CONV,FEAT,WEIGHT,IDLE}
//   pool_en             : pooling enable in CONV/WB of conv+pool layers
//   busy                : not IDLE
//   run_done            : pulse on normal completion of the last layer
//   err                 : sticky watchdog / reserved-descriptor error
// -----------------------------------------------------------------------------
module layer_sched
    import layer_sched_pkg::*;
#(
    parameter int               LAYER_W   = 4,
    parameter int               WDT_W     = 20,
    parameter logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_LIMIT_DEFAULT)
) (
    input  logic               sclk,
    input  logic               s_rst_n,
    input  logic               start,
    input  logic [LAYER_W-1:0] layer_num,
    output logic [LAYER_W-1:0] layer_idx,
    input  logic [1:0]         layer_type,
    input  logic               weight_done,
    input  logic               feat_done,
    input  logic               conv_done,
    input  logic               upsample_finish,
    input  logic               wb_done,
    output logic [5:0]         state,
    output logic               pool_en,
    output logic               busy,
    output logic               run_done,
    output logic               err
);

    phase_t             state_q;
    logic [LAYER_W-1:0] layer_idx_q;
    logic [LAYER_W-1:0] layer_last_q;
    logic               rom_wait_q;
    logic               pool_en_q;
    logic               run_done_q;
    logic               err_q;

    logic               adv;
    logic               wdt_clr;
    logic               wdt_en;
    logic               wdt_expired;

    // adv: the current phase is being left on the next edge.
    always_comb begin
        adv = 1'b0;
        case (state_q)
            ST_WEIGHT:   adv = weight_done;
            ST_FEAT:     adv = feat_done;
            ST_CONV:     adv = conv_done;
            ST_UPSAMPLE: adv = upsample_finish;
            ST_WB:       adv = rom_wait_q || wb_done;
            default:     adv = 1'b0;
        endcase
    end

    assign wdt_en  = (state_q != ST_IDLE);
    assign wdt_clr = adv || (state_q == ST_IDLE);

    layer_sched_wdt #(
        .WDT_W     (WDT_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) u_wdt (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q      <= ST_IDLE;
            layer_idx_q  <= '0;
            layer_last_q <= '0;
            rom_wait_q   <= 1'b0;
            pool_en_q    <= 1'b0;
            run_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            run_done_q <= 1'b0;
            if (wdt_expired) begin
                // Stalled phase: abort, keep layer_idx for debug.
                state_q    <= ST_IDLE;
                err_q      <= 1'b1;
                pool_en_q  <= 1'b0;
                rom_wait_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Whenever IDLE is reachable with err clear, layer_idx
                        // is 0, so layer_type here is the first layer's
                        // descriptor and the run can start without a ROM cycle.
                        if (start) begin
                            layer_idx_q <= '0;
                            if (err_q) begin
                                err_q <= 1'b0;
                            end else begin
                                layer_last_q <= layer_num;
                                state_q      <= first_phase(layer_type);
                                err_q        <= (layer_type == LT_RSVD);
                            end
                        end
                    end
                    ST_WEIGHT: begin
                        if (weight_done) state_q <= ST_FEAT;
                    end
                    ST_FEAT: begin
                        if (feat_done) begin
                            state_q   <= ST_CONV;
                            pool_en_q <= (layer_type == LT_CONV_POOL);
                        end
                    end
                    ST_CONV: begin
                        if (conv_done) state_q <= ST_WB;
                    end
                    ST_UPSAMPLE: begin
                        if (upsample_finish) state_q <= ST_WB;
                    end
                    ST_WB: begin
                        if (rom_wait_q) begin
                            // layer_idx advanced last edge; descriptor now valid.
                            rom_wait_q <= 1'b0;
                            state_q    <= first_phase(layer_type);
                            err_q      <= (layer_type == LT_RSVD);
                        end else if (wb_done) begin
                            pool_en_q <= 1'b0;
                            if (layer_idx_q == layer_last_q) begin
                                // Return the index to 0 so the ROM presents
                                // the first descriptor for the next run.
                                state_q     <= ST_IDLE;
                                run_done_q  <= 1'b1;
                                layer_idx_q <= '0;
                            end else begin
                                layer_idx_q <= layer_idx_q + LAYER_W'(1);
                                rom_wait_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        pool_en_q  <= 1'b0;
                        rom_wait_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state     = state_q;
    assign layer_idx = layer_idx_q;
    assign pool_en   = pool_en_q;
    assign run_done  = run_done_q;
    assign err       = err_q;
    assign busy      = ~state_q[PH_IDLE];

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 Parameter LAYER_W, default 4: width of layer counter and layer-count fields.
REQ-002 Parameter WDT_W, default 20: width of watchdog counter.
REQ-003 Parameter WDT_LIMIT, default 20'hF_FFFF: watchdog expiry count per phase.
REQ-004 sclk  input  1  system clock; all logic rising-edge.
REQ-005 s_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle pulse; begins a network run; ignored unless in IDLE.
REQ-007 layer_num  input  LAYER_W  layers in run, minus one; sampled on accepted start.
REQ-008 layer_idx  output  LAYER_W  index of current layer; drives external descriptor ROM.
REQ-009 layer_type  input  2  descriptor for layer_idx, valid same cycle: 0 conv, 1 conv+pool, 2 upsample, 3 reserved.
REQ-010 weight_done, feat_done, conv_done, upsample_finish, wb_done  input  1 each  single-cycle completion pulses from datapath stages.
REQ-011 state  output  6  one-hot phase vector: [0] IDLE, [1] WEIGHT, [2] FEAT, [3] CONV, [4] UPSAMPLE, [5] WB.
REQ-012 pool_en  output  1  high during CONV and WB when current layer_type is 1.
REQ-013 busy  output  1  high whenever state[0] is low.
REQ-014 run_done  output  1  single-cycle pulse on normal completion of last layer.
REQ-015 err  output  1  sticky watchdog/reserved-type error flag.

Function
REQ-016 state, layer_idx, pool_en, run_done, err SHALL be registered outputs; exactly one state bit high at all times.
REQ-017 IDLE: accepted start (start=1, err=0) -> layer_idx=0, latch layer_num, enter first phase next cycle.
REQ-018 First phase of each layer: type 0/1 -> WEIGHT; type 2 -> UPSAMPLE; type 3 -> IDLE with err=1.
REQ-019 WEIGHT -> FEAT on weight_done; FEAT -> CONV on feat_done; CONV -> WB on conv_done; UPSAMPLE -> WB on upsample_finish.
REQ-020 WB on wb_done: if layer_idx == latched layer_num -> IDLE, run_done pulse same edge; else layer_idx+1 and enter next layer's first phase, decided from layer_type one cycle after index update (one-cycle WB hold for ROM).
REQ-021 Completion pulses not matching the current phase SHALL be ignored.
REQ-022 Transition latency: phase change on edge after the matching done pulse; no bubble except REQ-020 ROM cycle.
REQ-023 Watchdog: counter clears on every phase change, increments each cycle in non-IDLE phase; at WDT_LIMIT -> IDLE, err=1, layer_idx held for debug.
REQ-024 err cleared only by reset or by start pulse while in IDLE; err-clearing start does not begin a run (second start required).
REQ-025 start while busy SHALL be ignored; layer_num changes while busy have no effect.
REQ-026 layer_num=0 runs exactly one layer; layer_idx SHALL not wrap.

Reset
REQ-027 Reset SHALL force state=6'b000001, layer_idx=0, watchdog=0, pool_en=0, run_done=0, err=0, latched layer_num=0.
REQ-028 Reset mid-run SHALL abort immediately; no run_done pulse issued.

Structure
REQ-029 Shared package: phase bit-position constants (IDLE..WB), layer_type encodings, WDT_LIMIT default.
REQ-030 One sub-module natural: layer_sched_wdt (loadable watchdog counter with clear/expire).
REQ-031 Phase FSM and layer counter reside in layer_sched; target 150-250 RTL lines.

Verification
REQ-032 layer_num=0, type 2; start -> state 000001->010000; upsample_finish -> 100000; wb_done -> 000001 + run_done pulse.
REQ-033 layer_num=2, types {0,1,2}: full sequence; pool_en high only in layer 1 CONV/WB; layer_idx 0->1->2; one run_done.
REQ-034 conv_done pulsed during WEIGHT and FEAT -> ignored; state unchanged.
REQ-035 WDT_LIMIT=16, stall in FEAT -> IDLE after 16 cycles, err=1, layer_idx held; next start clears err only.
REQ-036 type 3 at layer_idx=1 -> IDLE, err=1, no run_done.
REQ-037 s_rst_n low during CONV of layer 1 -> state=000001, layer_idx=0 asynchronously, no run_done.
